// File: rtl/vpu_blitter.sv
// VRAM port controller for a CPU register window: single-byte data access with
// auto-increment/prefetch, plus a fill/copy blitter. One outstanding VRAM transfer at a time.
module vpu_blitter #(
    parameter int ADDR_W = 13,
    parameter int OFFS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rw,
    input  logic [3:0]        ad,
    input  logic [7:0]        di,
    output logic [7:0]        dout,
    output logic              irq,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, CPU_WR, PREFETCH, FILL_WR, CP_RD, CP_WR, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   vaddr_q, vaddr_d, src_q, src_d, len_q, len_d;
    logic [7:0]          fill_q, fill_d, rdlatch_q, rdlatch_d;
    logic [OFFS_W-1:0]   offs_q, offs_d;
    logic                irq_q, irq_d, ien_q, ien_d, ovr_q, ovr_d;
    logic                mode_q, mode_d, dir_q, dir_d, aut_q, aut_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;

    logic                busy;
    logic [ADDR_W-1:0]   step_mag, vaddr_step, src_step;

    assign busy       = (state_q != IDLE);
    assign step_mag   = aut_q ? ADDR_W'(offs_q) : '0;
    assign vaddr_step = dir_q ? (vaddr_q - step_mag) : (vaddr_q + step_mag);
    assign src_step   = dir_q ? (src_q - step_mag) : (src_q + step_mag);

    assign irq       = irq_q & ien_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        dout = 8'h00;
        case (ad)
            4'h0:    dout = rdlatch_q;
            4'h2:    dout = 8'(vaddr_q >> 8);
            4'h3:    dout = vaddr_q[7:0];
            4'h4:    dout = {irq_q, ien_q, busy, ovr_q, 1'b0, mode_q, dir_q, aut_q};
            4'h5:    dout = 8'(offs_q);
            4'h6:    dout = 8'(len_q >> 8);
            4'h7:    dout = len_q[7:0];
            4'h8:    dout = 8'(src_q >> 8);
            4'h9:    dout = src_q[7:0];
            4'hA:    dout = fill_q;
            default: dout = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        vaddr_d   = vaddr_q;
        src_d     = src_q;
        len_d     = len_q;
        fill_d    = fill_q;
        rdlatch_d = rdlatch_q;
        offs_d    = offs_q;
        irq_d     = irq_q;
        ien_d     = ien_q;
        ovr_d     = ovr_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        aut_d     = aut_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        // CPU register access; transfers it launches only ever start from IDLE.
        if (cs) begin
            if (rw) begin
                if (ad == 4'h0 && !busy) begin
                    vaddr_d = vaddr_step;
                    state_d = PREFETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = vaddr_step;
                end
            end else begin
                case (ad)
                    4'h0: begin
                        if (busy) begin
                            ovr_d = 1'b1;
                        end else begin
                            state_d = CPU_WR;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = vaddr_q;
                            wdata_d = di;
                        end
                    end
                    4'h2: if (!busy) vaddr_d[ADDR_W-1:8] = di[ADDR_W-9:0];
                    4'h3: begin
                        if (!busy) begin
                            vaddr_d[7:0] = di;
                            state_d      = PREFETCH;
                            req_d        = 1'b1;
                            we_d         = 1'b0;
                            addr_d       = {vaddr_q[ADDR_W-1:8], di};
                        end
                    end
                    4'h4: begin
                        if (di[7]) irq_d = 1'b0;
                        if (di[4]) ovr_d = 1'b0;
                        ien_d = di[6];
                        if (!busy) begin
                            mode_d = di[2];
                            dir_d  = di[1];
                            aut_d  = di[0];
                        end
                        // The mode bit written alongside START selects the operation.
                        if (di[3]) begin
                            if (busy) begin
                                ovr_d = 1'b1;
                            end else if (len_q == '0) begin
                                state_d = DONE;
                            end else if (di[2]) begin
                                state_d = CP_RD;
                                req_d   = 1'b1;
                                we_d    = 1'b0;
                                addr_d  = src_q;
                            end else begin
                                state_d = FILL_WR;
                                req_d   = 1'b1;
                                we_d    = 1'b1;
                                addr_d  = vaddr_q;
                                wdata_d = fill_q;
                            end
                        end
                    end
                    4'h5: if (!busy) offs_d = di[OFFS_W-1:0];
                    4'h6: if (!busy) len_d[ADDR_W-1:8] = di[ADDR_W-9:0];
                    4'h7: if (!busy) len_d[7:0] = di;
                    4'h8: if (!busy) src_d[ADDR_W-1:8] = di[ADDR_W-9:0];
                    4'h9: if (!busy) src_d[7:0] = di;
                    4'hA: fill_d = di;
                    default: ;
                endcase
            end
        end

        case (state_q)
            CPU_WR: begin
                if (mem_ack) begin
                    vaddr_d = vaddr_step;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            PREFETCH: begin
                if (mem_ack) begin
                    rdlatch_d = mem_rdata;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end
            end
            FILL_WR: begin
                if (mem_ack) begin
                    vaddr_d = vaddr_step;
                    len_d   = len_q - 1'b1;
                    if (len_q == ADDR_W'(1)) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        addr_d  = vaddr_step;
                        wdata_d = fill_q;
                    end
                end
            end
            CP_RD: begin
                if (mem_ack) begin
                    src_d   = src_step;
                    we_d    = 1'b1;
                    addr_d  = vaddr_q;
                    wdata_d = mem_rdata;
                    state_d = CP_WR;
                end
            end
            CP_WR: begin
                if (mem_ack) begin
                    vaddr_d = vaddr_step;
                    len_d   = len_q - 1'b1;
                    we_d    = 1'b0;
                    if (len_q == ADDR_W'(1)) begin
                        req_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        addr_d  = src_q;
                        state_d = CP_RD;
                    end
                end
            end
            DONE: begin
                irq_d   = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vaddr_q   <= '0;
            src_q     <= '0;
            len_q     <= '0;
            fill_q    <= 8'h00;
            rdlatch_q <= 8'h00;
            offs_q    <= OFFS_W'(1);
            irq_q     <= 1'b0;
            ien_q     <= 1'b0;
            ovr_q     <= 1'b0;
            mode_q    <= 1'b0;
            dir_q     <= 1'b0;
            aut_q     <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            vaddr_q   <= vaddr_d;
            src_q     <= src_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            rdlatch_q <= rdlatch_d;
            offs_q    <= offs_d;
            irq_q     <= irq_d;
            ien_q     <= ien_d;
            ovr_q     <= ovr_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            aut_q     <= aut_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
